// File: rtl/intr_arbiter.sv
// Interrupt controller/arbiter: pending capture, masked priority arbitration, REQ/SERVICE handshake.
// Define INTR_EDGE_EN for edge-triggered pending with W1C; default is level mode.

module intr_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic pend_d, pend_q;

`ifdef INTR_EDGE_EN
  logic irq_d, irq_q;

  // A new rising edge wins over any clear arriving in the same cycle.
  always_comb begin
    irq_d  = irq;
    pend_d = (pend_q & ~clr) | (irq & ~irq_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;

  always_comb pend_d = irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= 1'b0;
    else      pend_q <= pend_d;
  end
`endif

  assign pend = pend_q;
endmodule

module intr_arbiter #(
  parameter int NSRC   = 4,
  parameter int PRIO_W = 2,
  parameter int ID_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  input  logic            j_hand,
  input  logic            mret_done,
  output logic            intr_excep,
  output logic [ID_W-1:0] claim_id,
  output logic            busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_e;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PRIO    = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;

  state_e                 state_d, state_q;
  logic [ID_W-1:0]        claim_d, claim_q;
  logic [NSRC-1:0]        enable_d, enable_q;
  logic [NSRC*PRIO_W-1:0] prio_d, prio_q;
  logic [NSRC-1:0]        pend, cand, clr;
  logic [ID_W-1:0]        win_id;
  logic                   win_vld;
  logic [PRIO_W-1:0]      win_prio;
  logic                   unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    intr_pend_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_src[g]),
      .clr  (clr[g]),
      .pend (pend[g])
    );
  end

  // Only the claimed source is cleared by the trap handshake; W1C can hit any bit.
  always_comb begin
    clr = '0;
    if (cfg_we && cfg_addr == A_PENDING) clr = cfg_wdata[NSRC-1:0];
    if (state_q == S_REQ && j_hand)      clr = clr | (NSRC'(1) << claim_q);
  end

  assign cand = pend & enable_q;

  // Strict '>' keeps the lowest index on equal priority.
  always_comb begin
    win_id   = '0;
    win_vld  = 1'b0;
    win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (cand[i] && (!win_vld || prio_q[i*PRIO_W +: PRIO_W] > win_prio)) begin
        win_vld  = 1'b1;
        win_prio = prio_q[i*PRIO_W +: PRIO_W];
        win_id   = ID_W'(i);
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    prio_d   = prio_q;
    if (cfg_we && cfg_addr == A_ENABLE) enable_d = cfg_wdata[NSRC-1:0];
    if (cfg_we && cfg_addr == A_PRIO)   prio_d   = cfg_wdata[NSRC*PRIO_W-1:0];
  end

  // claim_q is only loaded on IDLE->REQ, so later arrivals cannot pre-empt it.
  always_comb begin
    state_d = state_q;
    claim_d = claim_q;
    case (state_q)
      S_IDLE: if (win_vld) begin
        state_d = S_REQ;
        claim_d = win_id;
      end
      S_REQ:   if (j_hand)    state_d = S_SVC;
      S_SVC:   if (mret_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      claim_q  <= '0;
      enable_q <= '0;
      prio_q   <= '0;
    end else begin
      state_q  <= state_d;
      claim_q  <= claim_d;
      enable_q <= enable_d;
      prio_q   <= prio_d;
    end
  end

  assign intr_excep = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE);
  assign claim_id   = claim_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_ENABLE:  cfg_rdata = 32'(enable_q);
      A_PRIO:    cfg_rdata = 32'(prio_q);
      A_PENDING: cfg_rdata = 32'(pend);
      default:   cfg_rdata = 32'({busy, state_q, claim_q});
    endcase
  end
endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_intr_arbiter;
  localparam int NSRC = 4, PRIO_W = 2, ID_W = 3;
`ifdef INTR_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NSRC-1:0]        irq_src;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic [31:0]            cfg_rdata;
  logic                   j_hand, mret_done;
  logic                   intr_excep, busy;
  logic [ID_W-1:0]        claim_id;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  intr_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .j_hand(j_hand), .mret_done(mret_done),
    .intr_excep(intr_excep), .claim_id(claim_id), .busy(busy)
  );

  // Reference model: state 0=idle, 1=requesting, 2=servicing.
  logic [NSRC-1:0]        m_en, m_pend, m_prev;
  logic [NSRC*PRIO_W-1:0] m_prio;
  int                     m_state, m_claim;

  function automatic int f_winner(input logic [NSRC-1:0] c, input logic [NSRC*PRIO_W-1:0] pr);
    int best = -1;
    int id = 0;
    for (int i = 0; i < NSRC; i++)
      if (c[i] && int'(pr[i*PRIO_W +: PRIO_W]) > best) begin
        best = int'(pr[i*PRIO_W +: PRIO_W]);
        id = i;
      end
    return id;
  endfunction

  function automatic logic [NSRC-1:0] f_pend(input logic [NSRC-1:0] p, input logic [NSRC-1:0] prev,
                                             input logic [NSRC-1:0] src, input logic [NSRC-1:0] kill);
    if (EDGE) return (p & ~kill) | (src & ~prev);
    return src;
  endfunction

  function automatic logic [31:0] f_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_en);
      2'd1:    return 32'(m_prio);
      2'd2:    return 32'(m_pend);
      default: return 32'((m_state != 0 ? 1 : 0) * (1 << (ID_W + 2)) + m_state * (1 << ID_W) + m_claim);
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en <= '0; m_prio <= '0; m_pend <= '0; m_prev <= '0; m_state <= 0; m_claim <= 0;
    end else begin
      m_pend <= f_pend(m_pend, m_prev, irq_src,
                       ((cfg_we && cfg_addr == 2'd2) ? cfg_wdata[NSRC-1:0] : NSRC'(0)) |
                       ((m_state == 1 && j_hand) ? (NSRC'(1) << m_claim) : NSRC'(0)));
      m_prev <= irq_src;
      if (cfg_we && cfg_addr == 2'd0) m_en <= cfg_wdata[NSRC-1:0];
      if (cfg_we && cfg_addr == 2'd1) m_prio <= cfg_wdata[NSRC*PRIO_W-1:0];
      case (m_state)
        0: if ((m_pend & m_en) != 0) begin
          m_state <= 1;
          m_claim <= f_winner(m_pend & m_en, m_prio);
        end
        1:       if (j_hand) m_state <= 2;
        default: if (mret_done) m_state <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("intr_excep", 32'(intr_excep), 32'(m_state == 1));
      chk("busy",       32'(busy),       32'(m_state != 0));
      chk("claim_id",   32'(claim_id),   32'(m_claim));
      chk("cfg_rdata",  cfg_rdata,       f_rdata(cfg_addr));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; cyc(); cfg_we = 1'b0;
  endtask
  task automatic pulse_j();
    j_hand = 1'b1; cyc(); j_hand = 1'b0;
  endtask
  task automatic pulse_m();
    mret_done = 1'b1; cyc(); mret_done = 1'b0;
  endtask

  initial begin
    irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0; j_hand = 1'b0; mret_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_intr", 32'(intr_excep), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_claim", 32'(claim_id), 0);
    chk("rst_enable", cfg_rdata, 0);
    rst = 1'b1;

    // Basic request/service handshake and latency.
    wr(2'd0, 32'hF); wr(2'd1, 32'h0);
    irq_src = 4'b0100; cyc(); irq_src = '0;
    chk("t1_lat", 32'(intr_excep), 0);
    cyc();
    chk("t1_req", 32'(intr_excep), 1);
    chk("t1_id", 32'(claim_id), 2);
    cfg_addr = 2'd3; #1;
    chk("t1_status", cfg_rdata, 32'd42);
    pulse_j();
    chk("t1_svc_intr", 32'(intr_excep), 0);
    chk("t1_svc_busy", 32'(busy), 1);
    pulse_m();
    chk("t1_done", 32'(busy), 0);

    // Priority with a tie resolved to the lower index.
    wr(2'd1, 32'hCD);
    irq_src = 4'b1011; cyc(); irq_src = '0; cyc();
    chk("t2_id", 32'(claim_id), 1);
    chk("t2_req", 32'(intr_excep), 1);
    pulse_j(); wr(2'd2, 32'hF); pulse_m(); cyc();
    chk("t2_idle", 32'(busy), 0);

    // No pre-emption; the later high-priority source follows after mret.
    irq_src = 4'b0001; cyc(); irq_src = '0; cyc();
    chk("t3_id0", 32'(claim_id), 0);
    irq_src = 4'b1000; cyc(); cyc();
    chk("t3_frozen", 32'(claim_id), 0);
    chk("t3_still_req", 32'(intr_excep), 1);
    pulse_j(); pulse_m();
    chk("t3_idle", 32'(intr_excep), 0);
    cyc();
    chk("t3_rereq", 32'(intr_excep), 1);
    chk("t3_id3", 32'(claim_id), 3);
    irq_src = '0; pulse_j(); pulse_m(); cyc();
    chk("t3_clean", 32'(busy), 0);

    // Masked source stays pending but never requests.
    wr(2'd0, 32'hE);
    irq_src = 4'b0001; cyc(); irq_src = '0; cyc();
    cfg_addr = 2'd2; #1;
    chk("t4_pend", cfg_rdata, EDGE ? 32'h1 : 32'h0);
    chk("t4_noreq", 32'(intr_excep), 0);
    wr(2'd2, 32'h1); #1;
    chk("t4_w1c", cfg_rdata, 32'h0);
    wr(2'd0, 32'hF);

    // Single pulse serviced once; held line behaviour depends on mode.
    irq_src = 4'b0100; cyc(); irq_src = '0; cyc();
    chk("t5_req", 32'(intr_excep), 1);
    pulse_j(); pulse_m(); cyc();
    chk("t5_once", 32'(intr_excep), 0);
    irq_src = 4'b0100; cyc(); cyc();
    chk("t5_hold_req", 32'(intr_excep), 1);
    pulse_j(); pulse_m();
    chk("t5_mret_idle", 32'(busy), 0);
    cyc();
    chk("t5_rereq", 32'(intr_excep), EDGE ? 32'd0 : 32'd1);
    irq_src = '0; pulse_j(); pulse_m(); cyc();

    // Asynchronous reset while servicing.
    irq_src = 4'b0100; cyc(); irq_src = '0; cyc();
    pulse_j();
    chk("t6_svc", 32'(busy), 1);
    cfg_addr = 2'd0;
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_intr", 32'(intr_excep), 0);
    chk("t6_enable", cfg_rdata, 0);
    cyc();
    rst = 1'b1;
    wr(2'd0, 32'hF); wr(2'd1, $urandom);

    // Random traffic; the negedge compare process checks every cycle.
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) irq_src = NSRC'($urandom);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = $urandom;
      j_hand    = ($urandom_range(0, 2) == 0);
      mret_done = ($urandom_range(0, 3) == 0);
      cyc();
    end
    irq_src = '0; cfg_we = 1'b0; j_hand = 1'b0; mret_done = 1'b0;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
